balance_monitor: RTL
====================

BALANCE_MONITOR -- requirements
Module: balance_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of the lane data word.
REQ-002 SHALL have parameter SBIT_CNT_B, default $clog2(DATA_WIDTH)+1, width of one lane set-bit count, wide enough to hold DATA_WIDTH.
REQ-003 SHALL have parameter LANES, default 4, number of lanes (>=2).
REQ-004 SHALL have parameter WINDOW, default 16, accepted samples per evaluation window (>=2).
REQ-005 SHALL have parameter ACC_B, default 12, width of the per-lane accumulators and the difference outputs.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port en_i, input, 1, monitoring enable.
REQ-009 SHALL have port valid_i, input, 1, lane counts valid this cycle.
REQ-010 SHALL have port ready_o, output, 1, sample accepted when valid_i&&ready_o.
REQ-011 SHALL have port lane_sbit_cnt_i, input, [SBIT_CNT_B-1:0] x LANES, per-lane set-bit counts.
REQ-012 SHALL have port thresh_i, input, ACC_B, imbalance threshold.
REQ-013 SHALL have port balance_cnt_o, output, [ACC_B-1:0] x (LANES-1), registered |acc[i]-acc[i+1]| of the last window.
REQ-014 SHALL have port imbalance_o, output, LANES-1, per-pair flag balance_cnt_o[i] > thresh_i.
REQ-015 SHALL have port worst_pair_o, output, max(1,$clog2(LANES-1)), index of the largest balance_cnt_o.
REQ-016 SHALL have port done_o, output, 1, one-cycle pulse when the outputs update.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM and EVAL.
REQ-018 SHALL transition from IDLE to ACCUM on the first cycle en_i=1, with accumulators and the sample counter at zero.
REQ-019 SHALL drive ready_o=1 only in ACCUM.
REQ-020 SHALL, in ACCUM, on each accepted sample, add lane_sbit_cnt_i[l] (zero-extended) to acc[l] and increment the sample counter.
REQ-021 SHALL leave accumulators and the counter unchanged in ACCUM cycles with valid_i=0.
REQ-022 SHALL enter EVAL on the cycle after the WINDOW-th accepted sample.
REQ-023 SHALL, in EVAL, compute each difference at ACC_B+1 bits signed and register its magnitude into balance_cnt_o[i].
REQ-024 SHALL, in EVAL, register imbalance_o[i] using thresh_i sampled that cycle.
REQ-025 SHALL, in EVAL, register worst_pair_o as the lowest index among equal maxima.
REQ-026 SHALL, in EVAL, assert done_o for exactly that one cycle and clear accumulators and counter.
REQ-027 SHALL, from EVAL, go to ACCUM if en_i=1, else to IDLE.
REQ-028 SHALL, on en_i=0 in ACCUM, abort to IDLE next cycle, discard partial sums, emit no done_o and keep previous outputs.
REQ-029 SHALL hold balance_cnt_o, imbalance_o and worst_pair_o stable between EVAL cycles.
REQ-030 SHALL give a latency from WINDOW-th accepted sample to registered outputs and done_o of exactly 1 cycle.

Reset
REQ-031 SHALL, on rst_ni=0 at any time (including mid-window), asynchronously force state IDLE, accumulators and counter 0, balance_cnt_o 0, imbalance_o 0, worst_pair_o 0, done_o 0 and ready_o 0.
REQ-032 SHALL resume from IDLE on the first clock edge after rst_ni deasserts.

Configuration
REQ-033 SHALL, with macro BALANCE_MON_SAT_EN defined, saturate accumulators at 2^ACC_B-1 on overflow.
REQ-034 SHALL, without BALANCE_MON_SAT_EN, wrap accumulators modulo 2^ACC_B.

Verification
REQ-035 SHALL cover, with LANES=4, WINDOW=4 and thresh_i=5: counts {8,8,8,8} x4 -> done_o pulses once 1 cycle after 4th sample, balance_cnt_o={0,0,0}, imbalance_o=000, worst_pair_o=0.
REQ-036 SHALL cover counts {10,2,2,7} x4 -> balance_cnt_o={32,0,20}, imbalance_o=101, worst_pair_o=0.
REQ-037 SHALL cover valid_i toggled 1,0,1,0... -> done_o only after 4 accepted samples (8 cycles), ready_o=0 during EVAL.
REQ-038 SHALL cover en_i dropped after 2 samples -> IDLE, no done_o, outputs retain prior window values.
REQ-039 SHALL cover rst_ni pulsed low mid-window -> all outputs 0 immediately (asynchronously), next window starts fresh.
REQ-040 SHALL cover ACC_B=6, counts {33,0,0,0} x4 -> balance_cnt_o[0]=63 with BALANCE_MON_SAT_EN, 4 (132 mod 64) without.

Source files
------------

// File: rtl/balance_monitor.sv
// Lane balance monitor: accumulates per-lane set-bit counts over a window and reports pairwise imbalance.
// Optional macro BALANCE_MON_SAT_EN: saturate accumulators instead of wrapping modulo 2^ACC_B.
module balance_monitor #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SBIT_CNT_B = $clog2(DATA_WIDTH) + 1,
   parameter int unsigned LANES      = 4,
   parameter int unsigned WINDOW     = 16,
   parameter int unsigned ACC_B      = 12,
   localparam int unsigned WP_W      = (LANES > 2) ? $clog2(LANES - 1) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  en_i,
   input  logic                                  valid_i,
   output logic                                  ready_o,
   input  logic [LANES-1:0][SBIT_CNT_B-1:0]      lane_sbit_cnt_i,
   input  logic [ACC_B-1:0]                      thresh_i,
   output logic [LANES-2:0][ACC_B-1:0]           balance_cnt_o,
   output logic [LANES-2:0]                      imbalance_o,
   output logic [WP_W-1:0]                       worst_pair_o,
   output logic                                  done_o
);

   localparam int unsigned CNT_W = $clog2(WINDOW);
   localparam logic [ACC_B-1:0] ACC_MAX = '1;
`ifdef BALANCE_MON_SAT_EN
   localparam int unsigned SUM_W = ((SBIT_CNT_B > ACC_B) ? SBIT_CNT_B : ACC_B) + 1;
`endif

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL} state_t;

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic [ACC_B-1:0]             acc     [LANES];
   logic [ACC_B-1:0]             acc_sum [LANES];
   logic signed [ACC_B:0]        diff_c  [LANES-1];
   logic [LANES-2:0][ACC_B-1:0]  mag_c;
   logic [LANES-2:0]             imb_c;
   logic [WP_W-1:0]              worst_c;
   logic [ACC_B-1:0]             max_c;
`ifdef BALANCE_MON_SAT_EN
   logic [SUM_W-1:0]             sum_w   [LANES];
`endif

   // Accumulator values including the sample presented this cycle
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
`ifdef BALANCE_MON_SAT_EN
         sum_w[l]   = SUM_W'(acc[l]) + SUM_W'(lane_sbit_cnt_i[l]);
         acc_sum[l] = (sum_w[l] > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_B'(sum_w[l]);
`else
         acc_sum[l] = acc[l] + ACC_B'(lane_sbit_cnt_i[l]);
`endif
      end
   end

   // Pairwise magnitudes, threshold flags and first-maximum search over the final sums
   always_comb begin
      mag_c   = '0;
      imb_c   = '0;
      worst_c = '0;
      for (int i = 0; i < LANES - 1; i++) begin
         diff_c[i] = $signed({1'b0, acc_sum[i]}) - $signed({1'b0, acc_sum[i+1]});
         mag_c[i]  = diff_c[i][ACC_B] ? ACC_B'(-diff_c[i]) : ACC_B'(diff_c[i]);
         imb_c[i]  = mag_c[i] > thresh_i;
      end
      max_c = mag_c[0];
      for (int i = 1; i < LANES - 1; i++) begin
         if (mag_c[i] > max_c) begin
            max_c   = mag_c[i];
            worst_c = WP_W'(i);
         end
      end
   end

   // Window FSM; results are registered on the WINDOW-th accepted sample so they appear in EVAL
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= IDLE;
         cnt           <= '0;
         for (int l = 0; l < LANES; l++) acc[l] <= '0;
         balance_cnt_o <= '0;
         imbalance_o   <= '0;
         worst_pair_o  <= '0;
         done_o        <= 1'b0;
         ready_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (en_i) begin
                  state   <= ACCUM;
                  ready_o <= 1'b1;
                  cnt     <= '0;
                  for (int l = 0; l < LANES; l++) acc[l] <= '0;
               end
            end
            ACCUM: begin
               if (!en_i) begin
                  state   <= IDLE;
                  ready_o <= 1'b0;
                  cnt     <= '0;
                  for (int l = 0; l < LANES; l++) acc[l] <= '0;
               end else if (valid_i) begin
                  if (cnt == CNT_W'(WINDOW - 1)) begin
                     state         <= EVAL;
                     ready_o       <= 1'b0;
                     done_o        <= 1'b1;
                     balance_cnt_o <= mag_c;
                     imbalance_o   <= imb_c;
                     worst_pair_o  <= worst_c;
                     cnt           <= '0;
                     for (int l = 0; l < LANES; l++) acc[l] <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                     for (int l = 0; l < LANES; l++) acc[l] <= acc_sum[l];
                  end
               end
            end
            EVAL: begin
               cnt <= '0;
               for (int l = 0; l < LANES; l++) acc[l] <= '0;
               if (en_i) begin
                  state   <= ACCUM;
                  ready_o <= 1'b1;
               end else begin
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
